i2c_master_byte: RTL and testbench

// I2C single-byte master: the initiating end of the on-board I2C register bus. It issues one register write
// (START, dev+W, index, data, STOP) or one register read (START, dev+W, index, repeated START, dev+R, data, NACK, STOP).

---
 rtl/i2c_master_byte.sv | 232 +++++++++++++++++++++++
 tb/tb_i2c_master_byte.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_byte.sv
// Single-byte I2C register-bus master: one register write or one register read per request.
// SCL is push-pull; SDA is open-drain and read back through the inout for ACK and data slots.
module i2c_master_byte #(
  parameter int         CLK_DIV  = 25,
  parameter logic [6:0] DEV_ADDR = 7'h51
) (
  input  logic       gclk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rw,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rdata,
  output logic       sck,
  inout  wire        sda
);
  localparam int DIV_W = $clog2(CLK_DIV);

  typedef enum logic [3:0] {
    IDLE, START, TX_BYTE, TX_ACK, RESTART, RX_BYTE, RX_NACK, STOP, DONE
  } state_t;

  state_t           state, state_n;
  logic [DIV_W-1:0] div, div_n;
  logic [1:0]       q, q_n;
  logic [2:0]       bit_cnt, bit_cnt_n;
  logic [1:0]       byte_cnt, byte_cnt_n;
  logic             sck_n, sda_oe, sda_oe_n, ack_err_n, rw_r, rw_r_n;
  logic [7:0]       rdata_n, shreg, shreg_n, addr_r, wdata_r;
  logic             tick, sda_in, accept;

  assign sda    = sda_oe ? 1'b0 : 1'bz;
  assign sda_in = sda;
  assign busy   = (state != IDLE) && (state != DONE);
  assign done   = (state == DONE);
  assign tick   = (div == DIV_W'(CLK_DIV - 1));
  assign accept = (state == IDLE) && start;

  always_ff @(posedge gclk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      div      <= '0;
      q        <= 2'd0;
      bit_cnt  <= 3'd0;
      byte_cnt <= 2'd0;
      sck      <= 1'b1;
      sda_oe   <= 1'b0;
      ack_err  <= 1'b0;
      rdata    <= 8'h00;
      rw_r     <= 1'b0;
    end else begin
      state    <= state_n;
      div      <= div_n;
      q        <= q_n;
      bit_cnt  <= bit_cnt_n;
      byte_cnt <= byte_cnt_n;
      sck      <= sck_n;
      sda_oe   <= sda_oe_n;
      ack_err  <= ack_err_n;
      rdata    <= rdata_n;
      rw_r     <= rw_r_n;
    end
  end

  // Shift register and captured request fields carry data only, so they need no reset.
  always_ff @(posedge gclk) begin
    shreg <= shreg_n;
    if (accept) begin
      addr_r  <= reg_addr;
      wdata_r <= wdata;
    end
  end

  always_comb begin
    state_n    = state;
    div_n      = div;
    q_n        = q;
    bit_cnt_n  = bit_cnt;
    byte_cnt_n = byte_cnt;
    sck_n      = sck;
    sda_oe_n   = sda_oe;
    ack_err_n  = ack_err;
    rdata_n    = rdata;
    rw_r_n     = rw_r;
    shreg_n    = shreg;
    case (state)
      IDLE: begin
        div_n = '0;
        if (start) begin
          state_n    = START;
          q_n        = 2'd0;
          bit_cnt_n  = 3'd0;
          byte_cnt_n = 2'd0;
          ack_err_n  = 1'b0;
          rw_r_n     = rw;
          shreg_n    = {DEV_ADDR, 1'b0};
        end
      end
      DONE: begin
        div_n   = '0;
        state_n = IDLE;
      end
      default: begin
        div_n = tick ? '0 : div + 1'b1;
        if (tick) begin
          q_n = q + 2'd1;
          case (state)
            START: begin
              case (q)
                2'd0: sda_oe_n = 1'b0;
                2'd1: sda_oe_n = 1'b1;
                2'd2: begin
                  sck_n     = 1'b0;
                  q_n       = 2'd0;
                  bit_cnt_n = 3'd0;
                  state_n   = TX_BYTE;
                end
                default: ;
              endcase
            end
            TX_BYTE: begin
              case (q)
                2'd0: begin
                  sck_n    = 1'b0;
                  sda_oe_n = ~shreg[7];
                end
                2'd1: sck_n = 1'b1;
                2'd3: begin
                  sck_n     = 1'b0;
                  shreg_n   = {shreg[6:0], 1'b0};
                  bit_cnt_n = bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) state_n = TX_ACK;
                end
                default: ;
              endcase
            end
            TX_ACK: begin
              case (q)
                2'd0: begin
                  sck_n    = 1'b0;
                  sda_oe_n = 1'b0;
                end
                2'd1: sck_n = 1'b1;
                2'd2: if (sda_in) ack_err_n = 1'b1;
                2'd3: begin
                  sck_n      = 1'b0;
                  byte_cnt_n = byte_cnt + 2'd1;
                  // Any missing ACK abandons the remaining bytes but still closes with STOP.
                  if (ack_err) state_n = STOP;
                  else begin
                    case (byte_cnt)
                      2'd0: begin
                        shreg_n = addr_r;
                        state_n = TX_BYTE;
                      end
                      2'd1: begin
                        if (rw_r) state_n = RESTART;
                        else begin
                          shreg_n = wdata_r;
                          state_n = TX_BYTE;
                        end
                      end
                      default: state_n = rw_r ? RX_BYTE : STOP;
                    endcase
                  end
                end
                default: ;
              endcase
            end
            RESTART: begin
              case (q)
                2'd0: sda_oe_n = 1'b0;
                2'd1: sck_n = 1'b1;
                2'd2: sda_oe_n = 1'b1;
                2'd3: begin
                  sck_n   = 1'b0;
                  shreg_n = {DEV_ADDR, 1'b1};
                  state_n = TX_BYTE;
                end
                default: ;
              endcase
            end
            RX_BYTE: begin
              case (q)
                2'd0: begin
                  sck_n    = 1'b0;
                  sda_oe_n = 1'b0;
                end
                2'd1: sck_n = 1'b1;
                2'd2: shreg_n = {shreg[6:0], sda_in};
                2'd3: begin
                  sck_n     = 1'b0;
                  bit_cnt_n = bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) state_n = RX_NACK;
                end
                default: ;
              endcase
            end
            RX_NACK: begin
              case (q)
                2'd0: sda_oe_n = 1'b0;
                2'd1: sck_n = 1'b1;
                2'd3: begin
                  sck_n   = 1'b0;
                  if (!ack_err) rdata_n = shreg;
                  state_n = STOP;
                end
                default: ;
              endcase
            end
            STOP: begin
              case (q)
                2'd0: begin
                  sck_n    = 1'b0;
                  sda_oe_n = 1'b1;
                end
                2'd1: sck_n = 1'b1;
                2'd2: sda_oe_n = 1'b0;
                2'd3: state_n = DONE;
                default: ;
              endcase
            end
            default: ;
          endcase
        end
      end
    endcase
  end
endmodule

// File: tb/tb_i2c_master_byte.sv
// Bench for i2c_master_byte: a register-RAM slave at 0x51 decodes the bus into an event log,
// and table-driven transactions plus a few hand sequences are checked against hand-written values.
module tb_i2c_master_byte;
  localparam int CLK_DIV = 4;
  localparam int HALF_SCL = 2 * CLK_DIV;
  localparam int EV_S = -1;
  localparam int EV_P = -2;
  localparam int EV_NACK = -3;
  localparam int EV_ACK = -4;

  logic       gclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [7:0] reg_addr = 8'h00;
  logic [7:0] wdata = 8'h00;
  logic       busy, done, ack_err, sck;
  logic [7:0] rdata;
  wire        sda;
  logic       slv_oe;

  assign sda = slv_oe ? 1'b0 : 1'bz;
  pullup pu (sda);

  i2c_master_byte #(.CLK_DIV(CLK_DIV), .DEV_ADDR(7'h51)) dut (
    .gclk(gclk), .rst_n(rst_n), .start(start), .rw(rw), .reg_addr(reg_addr),
    .wdata(wdata), .busy(busy), .done(done), .ack_err(ack_err), .rdata(rdata),
    .sck(sck), .sda(sda)
  );

  always #5 gclk = ~gclk;

  // Slave / bus monitor state.
  logic       psck, psda, fresh, tx_mode, rd_mode, mack, mem_loaded = 1'b0;
  logic       ack_en = 1'b1;
  logic [7:0] shin, txsh, ptr;
  logic [7:0] mem [0:255];
  int         rcnt, frame, ecnt;
  int         tviol = 0;
  int         logq[$];

  always @(negedge gclk) begin
    if (!rst_n) begin
      psck <= sck; psda <= sda; slv_oe <= 1'b0; rcnt <= 0; frame <= 0;
      tx_mode <= 1'b0; rd_mode <= 1'b0; fresh <= 1'b0; ecnt <= 1;
      if (!mem_loaded) begin
        for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        mem[8'h20] <= 8'h5A;
        mem[8'h30] <= 8'hC3;
        mem_loaded <= 1'b1;
      end
    end else begin
      ecnt <= ecnt + 1;
      if (psck && sck && psda && !sda) begin
        logq.push_back(EV_S);
        rcnt <= 0; frame <= 0; tx_mode <= 1'b0; rd_mode <= 1'b0; fresh <= 1'b1;
      end else if (psck && sck && !psda && sda) begin
        logq.push_back(EV_P);
      end else if (!psck && sck) begin
        ecnt <= 1;
        if (ecnt != HALF_SCL) tviol <= tviol + 1;
        if (rcnt < 8) shin <= {shin[6:0], sda};
        else mack <= sda;
        rcnt <= (rcnt == 8) ? 0 : rcnt + 1;
      end else if (psck && !sck) begin
        ecnt <= 1;
        if (!fresh && ecnt != HALF_SCL) tviol <= tviol + 1;
        fresh <= 1'b0;
        if (rcnt == 8) begin
          if (tx_mode) slv_oe <= 1'b0;
          else begin
            logq.push_back(int'(shin));
            frame <= frame + 1;
            if (frame == 0) begin
              if (ack_en && shin[7:1] == 7'h51) begin
                slv_oe <= 1'b1; rd_mode <= shin[0];
              end else begin
                slv_oe <= 1'b0; rd_mode <= 1'b0;
              end
            end else if (frame == 1) begin
              ptr <= shin; slv_oe <= 1'b1;
            end else begin
              mem[ptr] <= shin; ptr <= ptr + 8'd1; slv_oe <= 1'b1;
            end
          end
        end else if (rcnt == 0 && !fresh) begin
          if (tx_mode) begin
            logq.push_back(int'(txsh));
            logq.push_back(mack ? EV_NACK : EV_ACK);
            tx_mode <= 1'b0; slv_oe <= 1'b0;
          end else if (rd_mode) begin
            tx_mode <= 1'b1; txsh <= mem[ptr]; slv_oe <= ~mem[ptr][7];
          end else slv_oe <= 1'b0;
        end else if (tx_mode) slv_oe <= ~txsh[7-rcnt];
      end
      psck <= sck; psda <= sda;
    end
  end

  typedef struct {
    bit         rw;
    logic [7:0] addr;
    logic [7:0] data;
    bit         ack;
    bit         exp_err;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vecs[12];
  int   n_pass = 0;
  int   n_tot = 0;
  int   exp_q[$];
  int   base, tv0;
  bit   seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_log(input string tag, input int from);
    chk({tag, " log_len"}, logq.size() - from, exp_q.size());
    for (int k = 0; k < exp_q.size(); k++)
      if (from + k < logq.size())
        chk($sformatf("%s log[%0d]", tag, k), logq[from+k], exp_q[k]);
  endtask

  task automatic start_txn(input bit r, input logic [7:0] a, input logic [7:0] d);
    @(negedge gclk);
    rw = r; reg_addr = a; wdata = d; start = 1'b1;
    @(negedge gclk);
    start = 1'b0; rw = ~r; reg_addr = ~a; wdata = ~d;
    chk("busy after start", busy, 1'b1);
  endtask

  task automatic wait_done(output bit got);
    got = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge gclk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    vecs[0]  = '{1'b0, 8'h10, 8'h3C, 1'b1, 1'b0, 8'h00};
    vecs[1]  = '{1'b1, 8'h10, 8'h00, 1'b1, 1'b0, 8'h3C};
    vecs[2]  = '{1'b1, 8'h20, 8'h00, 1'b1, 1'b0, 8'h5A};
    vecs[3]  = '{1'b0, 8'h20, 8'hA5, 1'b1, 1'b0, 8'h5A};
    vecs[4]  = '{1'b1, 8'h20, 8'h00, 1'b1, 1'b0, 8'hA5};
    vecs[5]  = '{1'b0, 8'h30, 8'h77, 1'b0, 1'b1, 8'hA5};
    vecs[6]  = '{1'b1, 8'h20, 8'h00, 1'b0, 1'b1, 8'hA5};
    vecs[7]  = '{1'b1, 8'h30, 8'h00, 1'b1, 1'b0, 8'hC3};
    vecs[8]  = '{1'b0, 8'h40, 8'hFF, 1'b1, 1'b0, 8'hC3};
    vecs[9]  = '{1'b1, 8'h40, 8'h00, 1'b1, 1'b0, 8'hFF};
    vecs[10] = '{1'b0, 8'h41, 8'h01, 1'b1, 1'b0, 8'hFF};
    vecs[11] = '{1'b1, 8'h41, 8'h00, 1'b1, 1'b0, 8'h01};

    repeat (3) @(negedge gclk);
    chk("reset sck", sck, 1'b1);
    chk("reset sda", sda, 1'b1);
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset ack_err", ack_err, 1'b0);
    chk("reset rdata", rdata, 8'h00);
    rst_n = 1'b1;
    repeat (2) @(negedge gclk);
    chk("idle busy", busy, 1'b0);

    for (int i = 0; i < 12; i++) begin
      ack_en = vecs[i].ack;
      base = logq.size();
      tv0 = tviol;
      start_txn(vecs[i].rw, vecs[i].addr, vecs[i].data);
      wait_done(seen);
      chk($sformatf("v%0d done seen", i), seen, 1'b1);
      chk($sformatf("v%0d busy at done", i), busy, 1'b0);
      chk($sformatf("v%0d ack_err", i), ack_err, vecs[i].exp_err);
      @(negedge gclk);
      chk($sformatf("v%0d done width", i), done, 1'b0);
      chk($sformatf("v%0d rdata", i), rdata, vecs[i].exp_rd);
      if (!vecs[i].ack) exp_q = '{EV_S, 'hA2, EV_P};
      else if (!vecs[i].rw) exp_q = '{EV_S, 'hA2, int'(vecs[i].addr), int'(vecs[i].data), EV_P};
      else exp_q = '{EV_S, 'hA2, int'(vecs[i].addr), EV_S, 'hA3, int'(vecs[i].exp_rd), EV_NACK, EV_P};
      check_log($sformatf("v%0d", i), base);
      chk($sformatf("v%0d scl timing", i), tviol - tv0, 0);
    end
    chk("nack write left mem", mem[8'h30], 8'hC3);

    // start while busy and during the done cycle are ignored; one cycle later is accepted
    ack_en = 1'b1;
    base = logq.size();
    start_txn(1'b0, 8'h50, 8'h66);
    repeat (100) @(negedge gclk);
    rw = 1'b1; reg_addr = 8'h99; wdata = 8'hEE; start = 1'b1;
    @(negedge gclk);
    start = 1'b0;
    chk("start while busy", busy, 1'b1);
    wait_done(seen);
    chk("seqA done1", seen, 1'b1);
    rw = 1'b0; reg_addr = 8'h51; wdata = 8'h77; start = 1'b1;
    @(negedge gclk);
    chk("start at done ignored", busy, 1'b0);
    chk("done single cycle", done, 1'b0);
    @(negedge gclk);
    start = 1'b0;
    chk("start after done accepted", busy, 1'b1);
    wait_done(seen);
    chk("seqA done2", seen, 1'b1);
    exp_q = '{EV_S, 'hA2, 'h50, 'h66, EV_P, EV_S, 'hA2, 'h51, 'h77, EV_P};
    check_log("seqA", base);
    @(negedge gclk);

    // reset in the middle of the data byte
    base = logq.size();
    start_txn(1'b0, 8'h60, 8'h12);
    seen = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge gclk);
      if (logq.size() >= base + 3) begin
        seen = 1'b1;
        break;
      end
    end
    chk("seqB reached data byte", seen, 1'b1);
    repeat (30) @(negedge gclk);
    chk("seqB pre-reset busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("seqB async sck", sck, 1'b1);
    chk("seqB async busy", busy, 1'b0);
    @(negedge gclk);
    #1;
    chk("seqB sda released", sda, 1'b1);
    chk("seqB rdata reset", rdata, 8'h00);
    chk("seqB done low", done, 1'b0);
    @(negedge gclk);
    rst_n = 1'b1;
    repeat (2) @(negedge gclk);
    exp_q = '{EV_S, 'hA2, 'h60};
    check_log("seqB aborted", base);
    chk("seqB mem untouched", mem[8'h60], 8'h00);
    base = logq.size();
    start_txn(1'b0, 8'h60, 8'h12);
    wait_done(seen);
    chk("seqB write done", seen, 1'b1);
    chk("seqB write ack_err", ack_err, 1'b0);
    @(negedge gclk);
    chk("seqB mem written", mem[8'h60], 8'h12);
    start_txn(1'b1, 8'h60, 8'h00);
    wait_done(seen);
    chk("seqB read done", seen, 1'b1);
    @(negedge gclk);
    chk("seqB readback", rdata, 8'h12);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
